rtlmem_1rwn_arb: RTL and testbench

Parametrised single-port memory shared by G_CH requesters through a round-robin arbiter. Each accepted access occupies the one RAM port for one cycle. Read data returns after a programmable G_PIPELINE latency and is tagged with a one-hot channel valid. A built-in clear engine overwrites the whole array with G_RST_VAL. The block sits wherever several engines share one table and no longer need an external mux.

---
 rtl/rtlmem_pkg.sv | 20 ++
 rtl/rtlmem_sp_core.sv | 57 +++++
 rtl/rtlmem_1rwn_arb.sv | 199 +++++++++++++++++++
 tb/tb_rtlmem_1rwn_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtlmem_pkg.sv
// Shared definitions for the rtlmem arbitrated single-port memory slice:
// clear-FSM state encoding, structural limits and the parity helper.
package rtlmem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  localparam int unsigned MAX_CH       = 8;
  localparam int unsigned MAX_PIPELINE = 3;
  localparam int unsigned PAR_MAX_W    = 64;

  // Even parity bit: XOR of all data bits, so data plus parity has even weight.
  // Callers zero-extend their data to PAR_MAX_W, which leaves the result unchanged.
  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rtlmem_sp_core.sv
// Inferred single-port array with a registered read stage followed by
// G_PIPELINE-1 further output stages. Each stage only loads when valid data
// flows into it, so the final stage holds the last read word.
module rtlmem_sp_core
  import rtlmem_pkg::*;
#(
  parameter int              G_AW       = 10,
  parameter int              G_DW       = 16,
  parameter int              G_DEPTH    = 1024,
  parameter int              G_PIPELINE = 2,
  parameter logic [G_DW-1:0] G_OOR_WORD = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic            re,
  input  logic            oor,
  input  logic [G_AW-1:0] addr,
  input  logic [G_DW-1:0] di,
  output logic [G_DW-1:0] dout
);

  logic [G_DW-1:0]       mem [G_DEPTH];
  logic [G_DW-1:0]       stg [G_PIPELINE];
  logic [G_PIPELINE-1:0] stg_vld;

  // Array write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= di;
    end
  end

  // Read register plus output stages; an out-of-range read loads the fill word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < G_PIPELINE; k++) begin
        stg[k] <= '0;
      end
      stg_vld <= '0;
    end else begin
      stg_vld[0] <= re;
      if (re) begin
        stg[0] <= oor ? G_OOR_WORD : mem[addr];
      end
      for (int unsigned k = 1; k < G_PIPELINE; k++) begin
        stg_vld[k] <= stg_vld[k-1];
        if (stg_vld[k-1]) begin
          stg[k] <= stg[k-1];
        end
      end
    end
  end

  assign dout = stg[G_PIPELINE-1];

endmodule

// File: rtl/rtlmem_1rwn_arb.sv
// Single-port memory shared by G_CH requesters via a round-robin arbiter,
// with a built-in clear engine and a one-hot read tag pipe.
// Optional feature macro: RTLMEM_PARITY_EN (adds an even-parity bit per word
// and drives rd_perr; without it rd_perr is tied low).
module rtlmem_1rwn_arb
  import rtlmem_pkg::*;
#(
  parameter int                 G_CH       = 4,
  parameter int                 G_ADDR     = 10,
  parameter int                 G_WIDTH    = 16,
  parameter int                 G_DEPTH    = 2**G_ADDR,
  parameter int                 G_PIPELINE = 2,
  parameter logic [G_WIDTH-1:0] G_RST_VAL  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clren,
  output logic                    clrrdy,
  input  logic [G_CH-1:0]         req_vld,
  input  logic [G_CH-1:0]         req_we,
  input  logic [G_CH*G_ADDR-1:0]  req_ad,
  input  logic [G_CH*G_WIDTH-1:0] req_di,
  output logic [G_CH-1:0]         req_gnt,
  output logic [G_CH-1:0]         rd_vld,
  output logic [G_WIDTH-1:0]      rd_do,
  output logic                    rd_perr
);

  localparam int CH_W = (G_CH > 1) ? $clog2(G_CH) : 1;
  localparam int AW   = (G_DEPTH > 1) ? $clog2(G_DEPTH) : 1;

`ifdef RTLMEM_PARITY_EN
  localparam int            DW       = G_WIDTH + 1;
  localparam logic [DW-1:0] RST_WORD = {parity_of(PAR_MAX_W'(G_RST_VAL)), G_RST_VAL};
`else
  localparam int            DW       = G_WIDTH;
  localparam logic [DW-1:0] RST_WORD = G_RST_VAL;
`endif

  if (G_CH < 2 || G_CH > int'(MAX_CH)) begin : g_bad_ch
    $error("rtlmem_1rwn_arb: G_CH out of range");
  end
  if (G_PIPELINE < 1 || G_PIPELINE > int'(MAX_PIPELINE)) begin : g_bad_pipe
    $error("rtlmem_1rwn_arb: G_PIPELINE out of range");
  end

  clr_state_t         state;
  logic [AW-1:0]      clr_cnt;
  logic [CH_W-1:0]    ptr;
  logic [G_CH-1:0]    gnt;
  logic [CH_W-1:0]    gnt_idx;
  int unsigned        idx;
  logic               arb_en;
  logic               accept;
  logic               sel_we;
  logic [G_ADDR-1:0]  sel_ad;
  logic [G_WIDTH-1:0] sel_di;
  logic               sel_oor;
  logic [DW-1:0]      wr_word;
  logic               ram_we;
  logic               ram_re;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_di;
  logic [DW-1:0]      core_q;
  logic [G_CH-1:0]    tag [G_PIPELINE];

  assign arb_en = (state == ST_IDLE) && !clren;

  // Round-robin search starting one past the last accepted channel.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    idx     = 0;
    if (arb_en) begin
      for (int unsigned k = 1; k <= G_CH; k++) begin
        idx = (32'(ptr) + k) % 32'(G_CH);
        if (gnt == '0 && req_vld[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = CH_W'(idx);
        end
      end
    end
  end

  assign req_gnt = gnt;
  assign accept  = |gnt;
  assign sel_we  = req_we[gnt_idx];
  assign sel_ad  = req_ad[int'(gnt_idx)*G_ADDR +: G_ADDR];
  assign sel_di  = req_di[int'(gnt_idx)*G_WIDTH +: G_WIDTH];
  assign sel_oor = 32'(sel_ad) >= 32'(G_DEPTH);

`ifdef RTLMEM_PARITY_EN
  assign wr_word = {parity_of(PAR_MAX_W'(sel_di)), sel_di};
`else
  assign wr_word = sel_di;
`endif

  // RAM port steering: clear engine owns the port while clearing.
  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = sel_ad[AW-1:0];
    ram_di   = wr_word;
    if (state == ST_CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = clr_cnt;
      ram_di   = RST_WORD;
    end else if (accept) begin
      if (sel_we) begin
        ram_we = !sel_oor;
      end else begin
        ram_re = 1'b1;
      end
    end
  end

  // Clear FSM with registered ready flag and word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      clrrdy  <= 1'b1;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clren) begin
            state   <= ST_CLEAR;
            clrrdy  <= 1'b0;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (32'(clr_cnt) == 32'(G_DEPTH - 1)) begin
            state   <= ST_IDLE;
            clrrdy  <= 1'b1;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          clrrdy <= 1'b1;
        end
      endcase
    end
  end

  // Round-robin pointer follows the accepted channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= CH_W'(G_CH - 1);
    end else if (accept) begin
      ptr <= gnt_idx;
    end
  end

  // One-hot read tag pipe, aligned with the core output stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < G_PIPELINE; k++) begin
        tag[k] <= '0;
      end
    end else begin
      tag[0] <= ram_re ? gnt : '0;
      for (int unsigned k = 1; k < G_PIPELINE; k++) begin
        tag[k] <= tag[k-1];
      end
    end
  end

  rtlmem_sp_core #(
    .G_AW       (AW),
    .G_DW       (DW),
    .G_DEPTH    (G_DEPTH),
    .G_PIPELINE (G_PIPELINE),
    .G_OOR_WORD (RST_WORD)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .oor  (sel_oor),
    .addr (ram_addr),
    .di   (ram_di),
    .dout (core_q)
  );

  assign rd_vld = tag[G_PIPELINE-1];
  assign rd_do  = core_q[G_WIDTH-1:0];

`ifdef RTLMEM_PARITY_EN
  // Out-of-range reads return RST_WORD, whose parity is consistent by construction.
  assign rd_perr = (|rd_vld) && (parity_of(PAR_MAX_W'(core_q[G_WIDTH-1:0])) != core_q[G_WIDTH]);
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_rtlmem_1rwn_arb.sv
// Directed bench for rtlmem_1rwn_arb: 4 channels, 16-word array, 5-bit address,
// read latency 2.
module tb_rtlmem_1rwn_arb;

  localparam int TB_CH    = 4;
  localparam int TB_ADDR  = 5;
  localparam int TB_W     = 16;
  localparam int TB_DEPTH = 16;
  localparam int TB_P     = 2;

  logic                     clk;
  logic                     rst;
  logic                     clren;
  logic                     clrrdy;
  logic [TB_CH-1:0]         req_vld;
  logic [TB_CH-1:0]         req_we;
  logic [TB_CH*TB_ADDR-1:0] req_ad;
  logic [TB_CH*TB_W-1:0]    req_di;
  logic [TB_CH-1:0]         req_gnt;
  logic [TB_CH-1:0]         rd_vld;
  logic [TB_W-1:0]          rd_do;
  logic                     rd_perr;

  int n_chk  = 0;
  int n_pass = 0;

  rtlmem_1rwn_arb #(
    .G_CH       (TB_CH),
    .G_ADDR     (TB_ADDR),
    .G_WIDTH    (TB_W),
    .G_DEPTH    (TB_DEPTH),
    .G_PIPELINE (TB_P),
    .G_RST_VAL  (16'h0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clren   (clren),
    .clrrdy  (clrrdy),
    .req_vld (req_vld),
    .req_we  (req_we),
    .req_ad  (req_ad),
    .req_di  (req_di),
    .req_gnt (req_gnt),
    .rd_vld  (rd_vld),
    .rd_do   (rd_do),
    .rd_perr (rd_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic we, input logic [TB_ADDR-1:0] ad,
                         input logic [TB_W-1:0] di);
    req_vld[ch] = 1'b1;
    req_we[ch]  = we;
    req_ad[ch*TB_ADDR +: TB_ADDR] = ad;
    req_di[ch*TB_W +: TB_W]       = di;
  endtask

  task automatic do_write(input int ch, input logic [TB_ADDR-1:0] ad, input logic [TB_W-1:0] di);
    set_req(ch, 1'b1, ad, di);
    #1;
    chk("wr_gnt", 32'(req_gnt), 32'd1 << ch);
    tick();
    req_vld[ch] = 1'b0;
    for (int i = 1; i < TB_P; i++) tick();
    chk("wr_no_rdvld", 32'(rd_vld), 32'd0);
  endtask

  task automatic do_read(input int ch, input logic [TB_ADDR-1:0] ad, input logic [TB_W-1:0] exp_d,
                         input logic exp_perr);
    set_req(ch, 1'b0, ad, '0);
    #1;
    chk("rd_gnt", 32'(req_gnt), 32'd1 << ch);
    tick();
    req_vld[ch] = 1'b0;
    for (int i = 1; i < TB_P; i++) tick();
    chk("rd_vld", 32'(rd_vld), 32'd1 << ch);
    chk("rd_do", 32'(rd_do), 32'(exp_d));
    chk("rd_perr", 32'(rd_perr), 32'(exp_perr));
    tick();
    chk("rd_vld_drop", 32'(rd_vld), 32'd0);
    chk("rd_do_hold", 32'(rd_do), 32'(exp_d));
  endtask

  initial begin
    logic [TB_CH-1:0] gh [16];
    logic [TB_W-1:0]  dh [16];
    logic [TB_CH-1:0] exp_g;
    int n;
    int bad_gnt;

    rst = 1'b1; clren = 1'b0;
    req_vld = '0; req_we = '0; req_ad = '0; req_di = '0;
    #3;
    chk("rst_clrrdy", 32'(clrrdy), 32'd1);
    chk("rst_rd_vld", 32'(rd_vld), 32'd0);
    chk("rst_rd_do", 32'(rd_do), 32'd0);
    chk("rst_rd_perr", 32'(rd_perr), 32'd0);
    #9 rst = 1'b0;
    tick();

    // Pointer resets to G_CH-1: with ch0 and ch3 requesting, ch0 wins.
    req_vld = 4'b1001;
    #1;
    chk("rst_ptr_gnt", 32'(req_gnt), 32'h1);
    req_vld = '0;
    tick();

    // Full clear: clrrdy low for exactly G_DEPTH cycles.
    clren = 1'b1;
    tick();
    clren = 1'b0;
    n = 0;
    while (clrrdy !== 1'b1 && n < 200) begin n++; tick(); end
    chk("clr_len", 32'(n), 32'd16);
    for (int a = 0; a < TB_DEPTH; a++) do_read(3, 5'(a), 16'h0000, 1'b0);

    // Four simultaneous writers granted 0,1,2,3 in consecutive cycles.
    for (int c = 0; c < TB_CH; c++) set_req(c, 1'b1, 5'(c + 1), 16'(16'hA0 + c));
    for (int c = 0; c < TB_CH; c++) begin
      #1;
      chk("wr4_gnt", 32'(req_gnt), 32'd1 << c);
      tick();
      req_vld[c] = 1'b0;
    end
    tick();
    for (int c = 0; c < TB_CH; c++) do_read(3, 5'(c + 1), 16'(16'hA0 + c), 1'b0);
    tick();

    // Ch1 (addr 1) and ch3 (addr 4) stream reads: grants alternate, tags follow after TB_P.
    set_req(1, 1'b0, 5'd1, '0);
    set_req(3, 1'b0, 5'd4, '0);
    for (int s = 0; s < 10; s++) begin
      if (s == 6) req_vld = '0;
      #1;
      exp_g = (s < 6) ? ((s % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
      gh[s] = exp_g;
      dh[s] = (s % 2 == 0) ? 16'h00A0 : 16'h00A3;
      chk("st_gnt", 32'(req_gnt), 32'(exp_g));
      if (s >= TB_P) begin
        chk("st_vld", 32'(rd_vld), 32'(gh[s-TB_P]));
        if (gh[s-TB_P] != '0) chk("st_do", 32'(rd_do), 32'(dh[s-TB_P]));
      end else begin
        chk("st_vld_lead", 32'(rd_vld), 32'd0);
      end
      tick();
    end

    // Clear requested with a read in flight and ch2 waiting.
    set_req(0, 1'b0, 5'd2, '0);
    #1;
    chk("cp_gnt0", 32'(req_gnt), 32'h1);
    tick();
    req_vld[0] = 1'b0;
    set_req(2, 1'b0, 5'd3, '0);
    clren = 1'b1;
    #1;
    chk("cp_clr_wins", 32'(req_gnt), 32'd0);
    tick();
    clren = 1'b0;
    chk("cp_pipe_vld", 32'(rd_vld), 32'h1);
    chk("cp_pipe_do", 32'(rd_do), 32'h00A1);
    n = 0;
    bad_gnt = 0;
    while (clrrdy !== 1'b1 && n < 200) begin
      if (req_gnt !== '0) bad_gnt++;
      n++;
      tick();
    end
    chk("cp_clr_len", 32'(n), 32'd16);
    chk("cp_gnt_blocked", 32'(bad_gnt), 32'd0);
    #1;
    chk("cp_gnt2", 32'(req_gnt), 32'h4);
    tick();
    req_vld[2] = 1'b0;
    for (int i = 1; i < TB_P; i++) tick();
    chk("cp_rd_vld", 32'(rd_vld), 32'h4);
    chk("cp_rd_do", 32'(rd_do), 32'h0000);
    tick();

    // Out-of-range: write to 20 dropped (would alias addr 4), read 20 gives fill value.
    do_write(0, 5'd4, 16'h1234);
    do_write(1, 5'd20, 16'hBEEF);
    tick();
    do_read(3, 5'd4, 16'h1234, 1'b0);
    do_read(2, 5'd20, 16'h0000, 1'b0);

`ifdef RTLMEM_PARITY_EN
    dut.u_core.mem[5][0] = ~dut.u_core.mem[5][0];
    do_read(0, 5'd5, 16'h0001, 1'b1);
    do_read(1, 5'd4, 16'h1234, 1'b0);
`endif

    // Reset during a clear returns to idle.
    clren = 1'b1;
    tick();
    clren = 1'b0;
    tick();
    tick();
    chk("mc_clrrdy_low", 32'(clrrdy), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("mc_rst_clrrdy", 32'(clrrdy), 32'd1);
    #1 rst = 1'b0;
    tick();
    chk("mc_idle_clrrdy", 32'(clrrdy), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
